// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// ----------------
// Multiplexed driver for a multi-digit, common-select, active-low 7-segment
// display. A packed hex word plus per-digit decimal-point and blank masks are
// captured on a load strobe into a staging buffer. They are promoted to the
// shadow (displayed) buffer only at a frame boundary, so a frame never mixes
// old and new data. Each digit is selected for PRESCALE cycles. The first
// BLANK_CYC cycles of every dwell keep all selects off, which suppresses
// ghosting between digits.
//
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking. When the
// shadow buffer is updated, any digit above digit 0 whose nibble and all
// higher nibbles are zero is forced dark.
//
// Parameters:
//   DIGITS     number of digits (1..8)
//   PRESCALE   clk cycles per digit dwell (>= 2)
//   BLANK_CYC  all-off cycles at the start of each dwell (< PRESCALE)
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   value       packed hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp_in       per-digit decimal point request, active-high
//   blank_in    per-digit force-dark request, active-high
//   load        one-cycle strobe capturing value/dp_in/blank_in
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point segment, active-low
//   sel         digit selects, active-low, at most one low
//   frame_tick  one-cycle pulse after the last digit's dwell ends
module seg7_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = 6 * DIGITS;

    localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] enc(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            4'hF:    code = 7'h0E;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

`ifdef SEG7_LZB_EN
    // Digits above 0 whose nibble and every higher nibble are zero.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v);
        logic [DIGITS-1:0] mask;
        logic              zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (v[4*i +: 4] == 4'h0);
            mask[i]    = zero_above;
        end
        return mask;
    endfunction
`endif

    logic [CW-1:0]       cnt_r;
    logic [IW-1:0]       idx_r;
    logic [IW-1:0]       idx_next_s;
    logic                frame_end_s;

    logic [SW-1:0]       staging_r;
    logic                pending_r;
    logic [4*DIGITS-1:0] shadow_val_r;
    logic [DIGITS-1:0]   shadow_dp_r;
    logic [DIGITS-1:0]   shadow_blank_r;
    // Cleared by reset so the display stays dark until real data arrives.
    logic                shadow_vld_r;

    logic [SW-1:0]       live_s;
    logic [SW-1:0]       src_s;
    logic [DIGITS-1:0]   blank_next_s;

    logic [3:0]          nibble_s;
    logic [6:0]          seg_s;
    logic                dp_s;
    logic [DIGITS-1:0]   sel_s;

    logic [6:0]          seg_r;
    logic                dp_r;
    logic [DIGITS-1:0]   sel_r;
    logic                frame_tick_r;

    // Frame boundary: last cycle of the last digit's dwell.
    always_comb begin
        frame_end_s = (cnt_r == CNT_LAST) && (idx_r == IDX_LAST);
    end

    // Next digit index, wrapping after the last digit.
    always_comb begin
        if (DIGITS == 1) begin
            idx_next_s = '0;
        end else if (idx_r == IDX_LAST) begin
            idx_next_s = '0;
        end else begin
            idx_next_s = idx_r + IW'(1);
        end
    end

    // Dwell counter and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            idx_r <= idx_next_s;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Source for a shadow update: the live inputs win when load collides
    // with the boundary, otherwise the staged copy is promoted.
    always_comb begin
        live_s       = {value, dp_in, blank_in};
        src_s        = load ? live_s : staging_r;
        blank_next_s = src_s[DIGITS-1:0];
`ifdef SEG7_LZB_EN
        blank_next_s = blank_next_s | lz_mask(src_s[SW-1 -: 4*DIGITS]);
`endif
    end

    // Staging capture and frame-synchronous shadow update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging_r      <= '0;
            pending_r      <= 1'b0;
            shadow_val_r   <= '0;
            shadow_dp_r    <= '0;
            shadow_blank_r <= '0;
            shadow_vld_r   <= 1'b0;
        end else begin
            if (load) begin
                staging_r <= live_s;
            end
            if (frame_end_s && (load || pending_r)) begin
                shadow_val_r   <= src_s[SW-1 -: 4*DIGITS];
                shadow_dp_r    <= src_s[2*DIGITS-1 -: DIGITS];
                shadow_blank_r <= blank_next_s;
                shadow_vld_r   <= 1'b1;
                pending_r      <= 1'b0;
            end else if (load) begin
                pending_r <= 1'b1;
            end
        end
    end

    // Output pattern for the current counter/index position.
    always_comb begin
        seg_s    = 7'h7F;
        dp_s     = 1'b1;
        sel_s    = '1;
        nibble_s = shadow_val_r[{idx_r, 2'b00} +: 4];
        if (!shadow_vld_r || (cnt_r < CNT_BLANK) || shadow_blank_r[idx_r]) begin
            seg_s = 7'h7F;
            dp_s  = 1'b1;
            sel_s = '1;
        end else begin
            sel_s[idx_r] = 1'b0;
            seg_s        = enc(nibble_s);
            dp_s         = ~shadow_dp_r[idx_r];
        end
    end

    // Registered pin drivers and frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            sel_r        <= '1;
            frame_tick_r <= 1'b0;
        end else begin
            seg_r        <= seg_s;
            dp_r         <= dp_s;
            sel_r        <= sel_s;
            frame_tick_r <= frame_end_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign sel        = sel_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Table-driven bench for seg7_scan_driver with DIGITS=4, PRESCALE=8,
// BLANK_CYC=2 (32-cycle frame). Each table row describes the expected
// content of one whole frame and an optional load issued during it.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  sel;
    logic        frame_tick;

    int n_checks;
    int n_errors;

    seg7_scan_driver #(
        .DIGITS    (4),
        .PRESCALE  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .sel        (sel),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][6:0] seg;     // expected code per digit, [0] = digit 0
        logic [3:0]      lit;     // digits expected to be driven
        logic [3:0]      dpm;     // digits expected to show dp
        bit              ld_en;   // issue a load during this frame
        int              ld_at;   // sample index after which load is driven
        logic [15:0]     ld_val;
        logic [3:0]      ld_dp;
        logic [3:0]      ld_blank;
    } row_t;

    row_t       tbl [23];
    logic [6:0] enc_ref [16];

    task automatic check(input string name, input int j,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (j=%0d): got %h, expected %h", name, j, got, exp);
        end
    endtask

    function automatic row_t mk(input logic [27:0] s, input logic [3:0] lit,
                                input logic [3:0] dpm, input bit ld_en,
                                input int ld_at, input logic [15:0] v,
                                input logic [3:0] d, input logic [3:0] b);
        row_t r;
        r.seg      = s;
        r.lit      = lit;
        r.dpm      = dpm;
        r.ld_en    = ld_en;
        r.ld_at    = ld_at;
        r.ld_val   = v;
        r.ld_dp    = d;
        r.ld_blank = b;
        return r;
    endfunction

    // Checks one 32-cycle frame. Sample j is taken on the falling edge after
    // the j-th rising edge of the frame; it reflects cnt=(j-1)%8, idx=(j-1)/8.
    task automatic run_frame(input row_t r);
        int         d;
        int         c;
        bit         lit;
        logic [3:0] exp_sel;
        logic [6:0] exp_seg;
        logic       exp_dp;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            d       = (j - 1) / 8;
            c       = (j - 1) % 8;
            lit     = (c >= 2) && r.lit[d];
            exp_sel = lit ? ~(4'b0001 << d) : 4'hF;
            exp_seg = lit ? r.seg[d] : 7'h7F;
            exp_dp  = lit ? ~r.dpm[d] : 1'b1;
            check("sel", j, 32'(sel), 32'(exp_sel));
            check("seg", j, 32'(seg), 32'(exp_seg));
            check("dp", j, 32'(dp), 32'(exp_dp));
            check("frame_tick", j, 32'(frame_tick), 32'(j == 32));
            if (r.ld_en && (r.ld_at < 31) && (j == r.ld_at + 1)) begin
                check("pending_set", j, 32'(dut.pending_r), 32'd1);
            end
            if (j == 32) begin
                check("pending_clr", j, 32'(dut.pending_r), 32'd0);
            end
            if (r.ld_en && (j == r.ld_at)) begin
                value    = r.ld_val;
                dp_in    = r.ld_dp;
                blank_in = r.ld_blank;
                load     = 1'b1;
            end else begin
                load     = 1'b0;
                value    = 16'h5A5A;   // ignored unless loaded
            end
        end
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] nib;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        load     = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'h0;
        blank_in = 4'h0;

        enc_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        tbl[0] = mk({4{7'h7F}}, 4'h0, 4'h0, 1'b1, 10, 16'h1234, 4'b0100, 4'h0);
        tbl[1] = mk({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'b0100,
                    1'b1, 12, 16'hABCD, 4'h0, 4'h0);
        tbl[2] = mk({7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 4'h0,
                    1'b1, 31, 16'hFFFF, 4'h0, 4'h0);
        tbl[3] = mk({4{7'h0E}}, 4'hF, 4'h0, 1'b1, 5, 16'h5678, 4'b0001, 4'b1010);
        tbl[4] = mk({7'h12, 7'h02, 7'h78, 7'h00}, 4'b0101, 4'b0001,
                    1'b1, 3, 16'h8880, 4'h0, 4'h0);
        for (int n = 0; n < 16; n++) begin
            nib = 4'(n + 1);
            if (n < 15) begin
                tbl[5+n] = mk({7'h00, 7'h00, 7'h00, enc_ref[n]}, 4'hF, 4'h0,
                              1'b1, 3, {12'h888, nib}, 4'h0, 4'h0);
            end else begin
                tbl[5+n] = mk({7'h00, 7'h00, 7'h00, enc_ref[n]}, 4'hF, 4'h0,
                              1'b1, 20, 16'h0042, 4'h0, 4'h0);
            end
        end
`ifdef SEG7_LZB_EN
        tbl[21] = mk({7'h40, 7'h40, 7'h19, 7'h24}, 4'b0011, 4'h0,
                     1'b1, 7, 16'h0000, 4'h0, 4'h0);
        tbl[22] = mk({4{7'h40}}, 4'b0001, 4'h0, 1'b0, 0, 16'h0000, 4'h0, 4'h0);
`else
        tbl[21] = mk({7'h40, 7'h40, 7'h19, 7'h24}, 4'hF, 4'h0,
                     1'b1, 7, 16'h0000, 4'h0, 4'h0);
        tbl[22] = mk({4{7'h40}}, 4'hF, 4'h0, 1'b0, 0, 16'h0000, 4'h0, 4'h0);
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_seg", 0, 32'(seg), 32'h7F);
        check("rst_dp", 0, 32'(dp), 32'd1);
        check("rst_sel", 0, 32'(sel), 32'hF);
        check("rst_tick", 0, 32'(frame_tick), 32'd0);
        check("rst_pending", 0, 32'(dut.pending_r), 32'd0);
        rst = 1'b0;

        // Back-to-back frames straight from reset release.
        for (int k = 0; k < 23; k++) begin
            run_frame(tbl[k]);
        end

        // Asynchronous reset in the middle of digit 0's dwell.
        repeat (5) @(negedge clk);
        check("pre_rst_sel", 5, 32'(sel), 32'hE);
        #1 rst = 1'b1;
        #1;
        check("async_seg", 0, 32'(seg), 32'h7F);
        check("async_dp", 0, 32'(dp), 32'd1);
        check("async_sel", 0, 32'(sel), 32'hF);
        check("async_tick", 0, 32'(frame_tick), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Dark for a full frame, tick exactly 32 cycles after release.
        run_frame(tbl[0]);
        // The load issued in that frame shows in the following one.
        run_frame(tbl[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed driver for a multi-digit, common-select, active-low 7-segment display, such as the Io board's 4-digit display. It takes a packed hex word plus per-digit decimal-point and blank masks. Inputs are double-buffered so the display updates only at frame boundaries, with no tearing. Digits are time-multiplexed with a programmable dwell and an anti-ghosting blank gap, and the block drives the segment, dp and digit-select pins directly.

Parameters:
DIGITS, 4, number of digits; legal range 1..8
PRESCALE, 50000, clk cycles each digit is selected (dwell); must be >= 2
BLANK_CYC, 500, cycles at the start of each dwell with all selects off; must be < PRESCALE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
value  in  4*DIGITS  packed hex nibbles; nibble i = value[4i+3:4i] drives digit i (digit 0 = rightmost)
dp_in  in  DIGITS  decimal point on per digit, active-high
blank_in  in  DIGITS  force digit dark, active-high
load  in  1  one-cycle strobe; captures value, dp_in and blank_in into staging
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point segment, active-low
sel  out  DIGITS  digit selects, active-low, at most one low
frame_tick  out  1  one-cycle pulse after the last digit's dwell ends

Behaviour:
- Reset (async, active-high) clears everything immediately:
  - outputs: seg=7'h7F, dp=1, sel=all ones, frame_tick=0
  - state: cnt=0, idx=0, staging=0, shadow=0, pending=0
- Counters:
  - cnt runs 0..PRESCALE-1 and wraps.
  - On the wrap, idx advances 0..DIGITS-1 and wraps to 0.
  - DIGITS=1 → idx is held at 0.
- Output registers are computed from the current cnt/idx, giving one cycle of latency:
  - cnt < BLANK_CYC → sel=all ones, seg=7'h7F, dp=1.
  - Otherwise, if blank_sh[idx]=1 → the digit is dark, identical to the line above.
  - Otherwise → sel[idx]=0 with other selects 1; seg=enc(shadow nibble idx); dp=~dp_sh[idx].
- enc, active-low {g..a}, values 0..F:
  - 0–7: 40,79,24,30,19,12,02,78
  - 8–F: 00,10,08,03,46,21,06,0E (hex)
- frame_tick is registered high for exactly one cycle following the edge where cnt=PRESCALE-1 and idx=DIGITS-1.
- Double buffering:
  - load=1 → staging <= {value, dp_in, blank_in}; pending <= 1. Repeated loads before a frame boundary: the last one wins.
  - Frame boundary (cnt=PRESCALE-1 and idx=DIGITS-1) with pending=1 → shadow <= staging; pending <= 0.
  - load coinciding with the frame boundary → shadow takes the live inputs directly and pending stays 0, so no value is lost or delayed by a full frame.
- Inputs are only sampled on a load cycle. Changes to value at any other time have no effect.
- Reset asserted mid-frame: scanning restarts at digit 0 after release, the display stays dark until the first post-load frame boundary, and no partial frame_tick is produced.

Optional Feature:
SEG7_LZB_EN (leading-zero blanking).
- Defined: at the shadow update, any digit i>0 whose nibble and all higher nibbles are 0 is treated as blanked (ORed into blank_sh). Digit 0 is never auto-blanked. Example: 0x0042 on 4 digits shows "  42"; 0x0000 shows "   0".
- Undefined: all digits are shown per blank_in only, and no extra logic is generated.

Test Plan:
- Reset behaviour (DIGITS=4, PRESCALE=8, BLANK_CYC=2): assert rst mid-dwell → seg=7F, dp=1, sel=F the same cycle, without waiting for a clk edge; after release, the display stays dark until the first load.
- Scan order and timing: load value=16'h1234, dp_in=4'b0100 →
  - after the next frame boundary, sel cycles E,D,B,7, each low for 6 cycles with 2 all-off cycles between digits;
  - seg=19,30,24,79 for digits 0..3;
  - dp=0 only while sel=B;
  - frame_tick once every 32 cycles.
- Tear-free update: load 16'hABCD while digit 1 is active → the current frame still shows the old value; the next frame shows 21,46,03,08.
- Boundary collision: pulse load (value=16'hFFFF) in exactly the frame-boundary cycle → the next frame shows 0E on all digits, and pending reads 0 afterwards.
- Blank mask and all codes:
  - blank_in=4'b1010 → sel never drives digits 1 or 3 low;
  - sweep nibbles 0..F on digit 0 → seg matches the enc table exactly.
- SEG7_LZB_EN build: load 16'h0042 → digits 3 and 2 dark, digits 1 and 0 show 19 and 24; load 16'h0000 → only digit 0 lit with 40.
